// File: rtl/vpu_cmd_arbiter.sv
// vpu_cmd_arbiter: round-robin sharing of the single vector-unit command port.
// One command is outstanding at a time. Grants are combinational in idle, the
// granted command is registered, completion and error pulses are registered.
module vpu_cmd_arbiter #(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned CMD_W     = 128,
   parameter logic [7:0]  VEC_CLASS = 8'h02,
   parameter int unsigned TIMEOUT   = 1024
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [NUM_REQ-1:0]         req_valid_i,
   input  logic [NUM_REQ*CMD_W-1:0]   req_cmd_i,
   output logic [NUM_REQ-1:0]         req_ready_o,
   output logic [NUM_REQ-1:0]         req_done_o,
   output logic [NUM_REQ-1:0]         req_err_o,
   output logic [CMD_W-1:0]           vpu_cmd_o,
   output logic                       vpu_cmd_valid_o,
   input  logic                       vpu_cmd_ready_i,
   input  logic                       vpu_cmd_done_i,
   output logic                       busy_o,
   output logic [$clog2(NUM_REQ)-1:0] grant_id_o
);

   localparam int unsigned IdxW = $clog2(NUM_REQ);
   localparam int unsigned CntW = $clog2(TIMEOUT) + 1;

   typedef enum logic [1:0] {StIdle, StIssue, StWaitDone} state_e;

   state_e              state_q, state_d;
   logic [CMD_W-1:0]    cmd_q, cmd_d;
   logic [IdxW-1:0]     gid_q, gid_d;
   logic [IdxW-1:0]     rr_q, rr_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [NUM_REQ-1:0]  done_q, done_d;
   logic [NUM_REQ-1:0]  err_q, err_d;

   logic [CMD_W-1:0]    cmd_arr [NUM_REQ];
   logic                grant_vld;
   logic [IdxW-1:0]     grant_idx;
   logic [CMD_W-1:0]    grant_cmd;
   logic [NUM_REQ-1:0]  grant_oh;
   logic [NUM_REQ-1:0]  gid_oh;
   logic                class_ok;
   logic                finish;
   logic                tout;
   int unsigned         scan_idx;

   // Served requester moves to lowest priority: pointer goes one past it.
   function automatic logic [IdxW-1:0] inc_wrap(input logic [IdxW-1:0] i);
      return (32'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
   endfunction

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_cmd_view
      assign cmd_arr[i] = req_cmd_i[i*CMD_W +: CMD_W];
   end

   // Round-robin scan: first valid requester at or above rr_q, with wrap.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      scan_idx  = 0;
      // Scan downward so the lowest offset from rr_q wins.
      for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
         scan_idx = (32'(rr_q) + 32'(k)) % NUM_REQ;
         if (req_valid_i[IdxW'(scan_idx)]) begin
            grant_vld = 1'b1;
            grant_idx = IdxW'(scan_idx);
         end
      end
   end

   assign grant_cmd = cmd_arr[grant_idx];
   assign grant_oh  = NUM_REQ'(1) << grant_idx;
   assign gid_oh    = NUM_REQ'(1) << gid_q;
   assign class_ok  = (grant_cmd[CMD_W-1 -: 8] == VEC_CLASS);

   // Done wins over timeout; done without ready in ISSUE is not a completion.
   assign finish = ((state_q == StIssue) && vpu_cmd_ready_i && vpu_cmd_done_i) ||
                   ((state_q == StWaitDone) && vpu_cmd_done_i);
   assign tout   = !finish && (state_q != StIdle) && (cnt_q == CntW'(TIMEOUT - 1));

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= StIdle;
      else       state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:     if (grant_vld && class_ok) state_d = StIssue;
         StIssue: begin
            if (finish || tout)        state_d = StIdle;
            else if (vpu_cmd_ready_i)  state_d = StWaitDone;
         end
         StWaitDone: if (finish || tout) state_d = StIdle;
         default:    state_d = StIdle;
      endcase
   end

   // Output decode and datapath next-state.
   always_comb begin
      req_ready_o = '0;
      cmd_d       = cmd_q;
      gid_d       = gid_q;
      rr_d        = rr_q;
      cnt_d       = cnt_q;
      done_d      = '0;
      err_d       = '0;
      unique case (state_q)
         StIdle: begin
            if (grant_vld) begin
               req_ready_o = grant_oh;
               cmd_d       = grant_cmd;
               gid_d       = grant_idx;
               cnt_d       = '0;
               // Wrong class: reject in place, never reaches the vector unit.
               if (!class_ok) begin
                  err_d = grant_oh;
                  rr_d  = inc_wrap(grant_idx);
               end
            end
         end
         StIssue, StWaitDone: begin
            cnt_d = cnt_q + 1'b1;
            if (finish) begin
               done_d = gid_oh;
               rr_d   = inc_wrap(gid_q);
            end else if (tout) begin
               err_d = gid_oh;
               rr_d  = inc_wrap(gid_q);
            end
         end
         default: ;
      endcase
   end

   // Datapath registers; reset drops any outstanding command silently.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cmd_q  <= '0;
         gid_q  <= '0;
         rr_q   <= '0;
         cnt_q  <= '0;
         done_q <= '0;
         err_q  <= '0;
      end else begin
         cmd_q  <= cmd_d;
         gid_q  <= gid_d;
         rr_q   <= rr_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
         err_q  <= err_d;
      end
   end

   assign vpu_cmd_o       = cmd_q;
   assign vpu_cmd_valid_o = (state_q == StIssue);
   assign busy_o          = (state_q != StIdle);
   assign grant_id_o      = gid_q;
   assign req_done_o      = done_q;
   assign req_err_o       = err_q;

endmodule

// File: tb/tb_vpu_cmd_arbiter.sv
// Bench for vpu_cmd_arbiter: grant table, directed multi-cycle sequences and a
// randomized run against a transaction-level round-robin model.
module tb_vpu_cmd_arbiter;

   localparam int NR = 4;
   localparam int CW = 128;
   localparam int TO = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic [NR-1:0]    req_valid;
   logic [NR*CW-1:0] req_cmd;
   logic [NR-1:0]    req_ready, req_done, req_err;
   logic [CW-1:0]    vpu_cmd;
   logic             vpu_cmd_valid, vpu_cmd_ready, vpu_cmd_done, busy;
   logic [1:0]       grant_id;

   int n_chk  = 0;
   int n_pass = 0;

   vpu_cmd_arbiter #(
      .NUM_REQ  (NR),
      .CMD_W    (CW),
      .VEC_CLASS(8'h02),
      .TIMEOUT  (TO)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .req_valid_i    (req_valid),
      .req_cmd_i      (req_cmd),
      .req_ready_o    (req_ready),
      .req_done_o     (req_done),
      .req_err_o      (req_err),
      .vpu_cmd_o      (vpu_cmd),
      .vpu_cmd_valid_o(vpu_cmd_valid),
      .vpu_cmd_ready_i(vpu_cmd_ready),
      .vpu_cmd_done_i (vpu_cmd_done),
      .busy_o         (busy),
      .grant_id_o     (grant_id)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         prime;      // requester served first with a bad class (-1: none)
      logic [3:0] valid;
      logic [7:0] cls;
      logic [3:0] exp_ready;
      logic       exp_err;
   } vec_t;

   vec_t       vecs[7];
   logic [7:0] bad_cls[4] = '{8'h05, 8'h00, 8'hFF, 8'h03};

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", name, act, exp);
   endtask

   function automatic logic [CW-1:0] mk_cmd(input logic [7:0] cls, input logic [7:0] op,
                                            input logic [31:0] tag);
      return {cls, op, 80'h0, tag};
   endfunction

   function automatic logic [NR-1:0] oh(input int i);
      return NR'(1) << i;
   endfunction

   function automatic int idx_of(input logic [NR-1:0] v);
      for (int i = 0; i < NR; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic set_cmd(input int i, input logic [CW-1:0] c);
      req_cmd[i*CW +: CW] = c;
   endtask

   // A cycle: drive just after posedge, sample on negedge.
   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0;
      vpu_cmd_ready = 1'b0;
      vpu_cmd_done = 1'b0;
      nxt();
      rst = 1'b0;
   endtask

   // Random-phase state
   int             rem[NR];
   bit             pres[NR];
   logic [CW-1:0]  cur[NR];
   int             rr_m, o_idx, exp_g, dly, wt, left;
   bit             outst, o_err, acc;
   logic [CW-1:0]  o_cmd;

   initial begin
      int ord[8];
      int rem2[NR];
      int ng, bp_bad;
      logic [NR-1:0] errs;
      logic [CW-1:0] c;

      vecs[0] = '{-1, 4'b0000, 8'h02, 4'b0000, 1'b0};
      vecs[1] = '{-1, 4'b0110, 8'h02, 4'b0010, 1'b0};
      vecs[2] = '{ 0, 4'b0001, 8'h05, 4'b0001, 1'b1};
      vecs[3] = '{ 1, 4'b0011, 8'h02, 4'b0001, 1'b0};
      vecs[4] = '{ 2, 4'b1111, 8'h05, 4'b1000, 1'b1};
      vecs[5] = '{ 3, 4'b1100, 8'h02, 4'b0100, 1'b0};
      vecs[6] = '{ 1, 4'b1010, 8'h02, 4'b1000, 1'b0};

      req_cmd = '0;
      do_reset();
      smp();
      chk("reset_outputs", {req_ready, req_done, req_err, vpu_cmd_valid, busy, grant_id}, 0);
      chk("reset_vpu_cmd", vpu_cmd, 0);
      nxt();

      // Grant table: prime the round-robin pointer, then present a pattern.
      for (int n = 0; n < 7; n++) begin
         do_reset();
         if (vecs[n].prime >= 0) begin
            req_valid = oh(vecs[n].prime);
            set_cmd(vecs[n].prime, mk_cmd(8'h05, 8'h00, 99));
            smp();
            nxt();
         end
         req_valid = vecs[n].valid;
         for (int i = 0; i < NR; i++) set_cmd(i, mk_cmd(vecs[n].cls, 8'h10, i));
         smp();
         chk($sformatf("vec%0d_ready", n), req_ready, vecs[n].exp_ready);
         nxt();
         req_valid = '0;
         smp();
         if (vecs[n].exp_ready != 0) begin
            chk($sformatf("vec%0d_err", n), req_err, vecs[n].exp_err ? vecs[n].exp_ready : 4'b0);
            chk($sformatf("vec%0d_issue", n), vpu_cmd_valid, !vecs[n].exp_err);
            chk($sformatf("vec%0d_gid", n), grant_id, idx_of(vecs[n].exp_ready));
         end else begin
            chk($sformatf("vec%0d_busy", n), busy, 0);
         end
         nxt();
      end

      // Single requester: ready one cycle after valid, done three cycles later.
      do_reset();
      c = mk_cmd(8'h02, 8'h34, 32'hA0);
      req_valid = 4'b0001;
      set_cmd(0, c);
      smp(); chk("single_ready", req_ready, 4'b0001); nxt();
      req_valid = '0;
      smp();
      chk("single_valid", vpu_cmd_valid, 1);
      chk("single_cmd", vpu_cmd, c);
      chk("single_ready_once", req_ready, 0);
      nxt();
      vpu_cmd_ready = 1'b1;
      smp(); chk("single_valid_hold", vpu_cmd_valid, 1); nxt();
      vpu_cmd_ready = 1'b0;
      smp(); chk("single_valid_drop", {busy, vpu_cmd_valid}, 2'b10); nxt();
      smp(); nxt();
      vpu_cmd_done = 1'b1;
      smp(); chk("single_no_early_done", req_done, 0); nxt();
      vpu_cmd_done = 1'b0;
      smp();
      chk("single_done", req_done, 4'b0001);
      chk("single_idle", {busy, grant_id}, 0);
      nxt();
      smp(); chk("single_done_once", req_done, 0); nxt();

      // Contention: all requesters, two commands each.
      do_reset();
      ng = 0;
      for (int i = 0; i < 8; i++) ord[i] = -1;
      for (int i = 0; i < NR; i++) rem2[i] = 2;
      for (int cy = 0; cy < 100 && ng < 8; cy++) begin
         for (int i = 0; i < NR; i++) begin
            req_valid[i] = rem2[i] > 0;
            set_cmd(i, mk_cmd(8'h02, 8'h20, 32'(i * 2 + rem2[i])));
         end
         vpu_cmd_ready = 1'b1;
         vpu_cmd_done = 1'b1;
         smp();
         if (req_ready != 0) begin
            ord[ng] = idx_of(req_ready);
            if (ord[ng] >= 0) rem2[ord[ng]]--;
            ng++;
         end
         nxt();
      end
      req_valid = '0;
      vpu_cmd_ready = 1'b0;
      vpu_cmd_done = 1'b0;
      chk("cont_count", ng, 8);
      for (int k = 0; k < 8; k++) chk($sformatf("cont_grant%0d", k), ord[k], k % NR);

      // Bad class from requester 2.
      do_reset();
      req_valid = 4'b0100;
      set_cmd(2, mk_cmd(8'h05, 8'h34, 2));
      smp(); chk("bad_ready", req_ready, 4'b0100); nxt();
      req_valid = '0;
      smp();
      chk("bad_err", req_err, 4'b0100);
      chk("bad_no_issue", {vpu_cmd_valid, busy, req_done}, 0);
      nxt();
      errs = '0;
      for (int k = 0; k < 3; k++) begin
         smp();
         errs = errs | req_err | req_done | {3'b0, vpu_cmd_valid};
         nxt();
      end
      chk("bad_quiet", errs, 0);

      // Backpressure: ready held low for 10 cycles.
      do_reset();
      c = mk_cmd(8'h02, 8'h55, 32'hB1);
      req_valid = 4'b0010;
      set_cmd(1, c);
      smp(); chk("bp_ready", req_ready, 4'b0010); nxt();
      req_valid = '0;
      bp_bad = 0;
      for (int k = 0; k < 10; k++) begin
         smp();
         if (vpu_cmd_valid !== 1'b1 || vpu_cmd !== c) bp_bad++;
         nxt();
      end
      chk("bp_stable", bp_bad, 0);
      vpu_cmd_ready = 1'b1;
      smp(); chk("bp_valid_at_ready", vpu_cmd_valid, 1); nxt();
      vpu_cmd_ready = 1'b0;
      smp(); chk("bp_accepted", {busy, vpu_cmd_valid}, 2'b10); nxt();
      vpu_cmd_done = 1'b1;
      smp(); nxt();
      vpu_cmd_done = 1'b0;
      smp(); chk("bp_done", req_done, 4'b0010); nxt();

      // Timeout: done never arrives.
      do_reset();
      req_valid = 4'b1000;
      set_cmd(3, mk_cmd(8'h02, 8'h40, 3));
      smp(); chk("to_ready", req_ready, 4'b1000); nxt();
      req_valid = '0;
      errs = '0;
      for (int k = 0; k < TO; k++) begin
         vpu_cmd_ready = (k == 2);
         smp();
         errs = errs | req_err | req_done;
         if (k == 3) chk("to_wait_state", {busy, vpu_cmd_valid}, 2'b10);
         nxt();
      end
      vpu_cmd_ready = 1'b0;
      chk("to_no_early_pulse", errs, 0);
      smp();
      chk("to_err", req_err, 4'b1000);
      chk("to_idle", {busy, vpu_cmd_valid, req_done}, 0);
      nxt();
      vpu_cmd_done = 1'b1;
      smp(); nxt();
      vpu_cmd_done = 1'b0;
      smp(); chk("late_done_ignored", {req_done, req_err, busy}, 0); nxt();
      // Next request served normally, with ready and done together.
      c = mk_cmd(8'h02, 8'h34, 32'hC0);
      req_valid = 4'b0001;
      set_cmd(0, c);
      smp(); chk("after_to_ready", req_ready, 4'b0001); nxt();
      req_valid = '0;
      vpu_cmd_ready = 1'b1;
      vpu_cmd_done = 1'b1;
      smp(); chk("rd_same_valid", vpu_cmd_valid, 1); nxt();
      vpu_cmd_ready = 1'b0;
      vpu_cmd_done = 1'b0;
      smp();
      chk("rd_same_done", req_done, 4'b0001);
      chk("rd_same_no_wait", {busy, vpu_cmd_valid}, 0);
      nxt();

      // Reset during WAIT_DONE aborts silently and clears the pointer.
      do_reset();
      req_valid = 4'b0100;
      set_cmd(2, mk_cmd(8'h02, 8'h66, 32'hD2));
      smp(); nxt();
      req_valid = '0;
      vpu_cmd_ready = 1'b1;
      smp(); nxt();
      vpu_cmd_ready = 1'b0;
      smp(); chk("rst_pre_wait", {busy, vpu_cmd_valid}, 2'b10); nxt();
      rst = 1'b1;
      vpu_cmd_done = 1'b1;
      smp(); nxt();
      rst = 1'b0;
      vpu_cmd_done = 1'b0;
      smp();
      chk("rst_outputs", {req_ready, req_done, req_err, vpu_cmd_valid, busy, grant_id}, 0);
      chk("rst_vpu_cmd", vpu_cmd, 0);
      nxt();
      smp(); chk("rst_no_pulse", {req_done, req_err}, 0); nxt();
      req_valid = 4'b1001;
      set_cmd(0, mk_cmd(8'h02, 8'h01, 0));
      set_cmd(3, mk_cmd(8'h02, 8'h01, 3));
      smp(); chk("rst_rr_ptr", req_ready, 4'b0001); nxt();
      req_valid = '0;

      // Randomized traffic against a transaction-level model.
      do_reset();
      rr_m = 0; outst = 0; acc = 0; wt = 0; dly = 0; o_idx = 0; o_err = 0; o_cmd = '0;
      for (int i = 0; i < NR; i++) begin
         rem[i] = 6;
         pres[i] = 0;
         cur[i] = '0;
      end
      left = NR * 6;
      for (int cy = 0; cy < 3000 && (left > 0 || outst); cy++) begin
         for (int i = 0; i < NR; i++) begin
            if (!pres[i] && rem[i] > 0 && $urandom_range(2) != 0) begin
               pres[i] = 1;
               cur[i] = mk_cmd(($urandom_range(3) == 0) ? bad_cls[$urandom_range(3)] : 8'h02,
                               8'($urandom), $urandom);
            end
            req_valid[i] = pres[i];
            set_cmd(i, cur[i]);
         end
         if (acc) begin
            vpu_cmd_ready = 1'b0;
            vpu_cmd_done = (dly == 0);
         end else begin
            vpu_cmd_ready = ($urandom_range(1) == 1) || (wt >= 3);
            vpu_cmd_done = vpu_cmd_ready && ($urandom_range(3) == 0);
         end
         smp();
         if ((req_done | req_err) != 0) begin
            chk("rand_done", req_done, (outst && !o_err) ? oh(o_idx) : 4'b0);
            chk("rand_err", req_err, (outst && o_err) ? oh(o_idx) : 4'b0);
            if (outst) rr_m = (o_idx + 1) % NR;
            outst = 0;
         end
         exp_g = -1;
         if (!outst) begin
            for (int k = NR - 1; k >= 0; k--) if (pres[(rr_m + k) % NR]) exp_g = (rr_m + k) % NR;
         end
         if (req_ready != 0 || exp_g >= 0) begin
            chk("rand_grant", req_ready, (exp_g >= 0) ? oh(exp_g) : 4'b0);
            if (exp_g >= 0) begin
               outst = 1;
               o_idx = exp_g;
               o_cmd = cur[exp_g];
               o_err = (cur[exp_g][CW-1 -: 8] != 8'h02);
               pres[exp_g] = 0;
               rem[exp_g]--;
               left--;
            end
         end
         if (acc) begin
            if (vpu_cmd_done) acc = 0;
            else dly--;
         end else if (vpu_cmd_valid) begin
            wt++;
            if (vpu_cmd_ready) begin
               chk("rand_vpu_cmd", vpu_cmd, o_cmd);
               wt = 0;
               if (!vpu_cmd_done) begin
                  acc = 1;
                  dly = $urandom_range(3);
               end
            end
         end
         nxt();
      end
      chk("rand_drain", {31'(left), outst}, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/vpu_cmd_arbiter.md
Name: vpu_cmd_arbiter

Overview:
Shares the single vector_unit command port among NUM_REQ independent requesters, such as the tile sequencer, the DMA post-processor and the debug port. It arbitrates round-robin and keeps one command outstanding at a time. It registers the granted 128-bit command, drives the vector_unit valid/ready handshake, and routes cmd_done back to the originating requester. It also rejects commands whose class byte is not the vector class, and aborts on a watchdog timeout.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
CMD_W, 128, command width
VEC_CLASS, 8'h02, required value of cmd[127:120]
TIMEOUT, 1024, max cycles from issue until vpu_cmd_done (counter width is $clog2(TIMEOUT)+1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  per-requester command valid
req_cmd  in  NUM_REQ*CMD_W  flattened commands; requester i occupies bits [i*CMD_W +: CMD_W]
req_ready  out  NUM_REQ  one-cycle accept pulse to the granted requester
req_done  out  NUM_REQ  one-cycle completion pulse
req_err  out  NUM_REQ  one-cycle error pulse (bad class or timeout)
vpu_cmd  out  CMD_W  command to vector_unit cmd
vpu_cmd_valid  out  1  to vector_unit cmd_valid
vpu_cmd_ready  in  1  from vector_unit cmd_ready
vpu_cmd_done  in  1  from vector_unit cmd_done
busy  out  1  high whenever state != IDLE
grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester

Behaviour:
- Clock and reset:
  - Single clock domain clk. Reset is synchronous and active-high on rst.
  - Reset forces: state=IDLE, all outputs 0, vpu_cmd=0, rr_ptr=0, timeout counter=0.
  - rst asserted in any state aborts the outstanding command silently: no req_done, no req_err.
- States: IDLE, ISSUE, WAIT_DONE.
- IDLE:
  - If any req_valid is high, grant g = the first set bit scanning upward from rr_ptr with wrap-around.
  - In the same cycle: pulse req_ready[g] (combinational from registered state plus req_valid), capture req_cmd[g] into cmd_reg, set grant_id=g.
  - If cmd_reg[127:120] != VEC_CLASS: pulse req_err[g] on the next cycle, set rr_ptr=g+1 mod NUM_REQ, stay IDLE. Nothing is issued.
  - Otherwise go to ISSUE.
  - A requester must hold req_valid and req_cmd stable until req_ready. It may drop req_valid on the cycle after req_ready.
- ISSUE:
  - vpu_cmd=cmd_reg and vpu_cmd_valid=1, held stable until vpu_cmd_ready is sampled high.
  - On the ready edge, vpu_cmd_valid deasserts on the next cycle and the state goes to WAIT_DONE.
  - If vpu_cmd_done is high in the same cycle as vpu_cmd_ready, the command is treated as complete (go to completion, skip WAIT_DONE).
- WAIT_DONE:
  - On vpu_cmd_done: pulse req_done[g] for exactly one cycle (registered, the cycle after done is sampled), set rr_ptr=g+1 mod NUM_REQ, go to IDLE.
- Back-to-back operation:
  - A new grant may occur on the cycle req_done is pulsed.
  - Minimum accept-to-accept spacing is 4 cycles when the VPU answers with ready and done in 1 cycle each.
- Timeout:
  - The counter clears on entry to ISSUE and increments each cycle in ISSUE or WAIT_DONE.
  - When it reaches TIMEOUT-1 without completion: pulse req_err[g], drop vpu_cmd_valid, rr_ptr=g+1, go to IDLE.
  - A vpu_cmd_done arriving later while in IDLE is ignored.
  - If done and timeout occur in the same cycle, done wins.
- Fairness and encoding:
  - A requester that was just served has the lowest priority next round. Starvation is bounded by NUM_REQ-1 commands.
  - req_ready, req_done and req_err are each one-hot or zero.
  - vpu_cmd holds its last value while idle; vpu_cmd_valid is 0.

Test Plan:
- Single requester: req0 issues class 02, op 34 (VOP_ZERO); VPU ready after 1 cycle, done 3 cycles later -> one req_ready[0] pulse, vpu_cmd_valid high exactly until the ready edge, one req_done[0] pulse, busy back to 0, grant_id=0.
- Contention: all 4 req_valid held high, each requester issuing 2 commands -> grant order 0,1,2,3,0,1,2,3. No requester is granted twice before the others are served.
- Bad class: req2 issues cmd[127:120]=8'h05 -> req_ready[2] then req_err[2]; vpu_cmd_valid never rises; req_done stays 0.
- Backpressure: vpu_cmd_ready held low for 10 cycles -> vpu_cmd and vpu_cmd_valid remain stable for all 10 cycles; the command is accepted on the first ready cycle.
- Timeout: TIMEOUT=16 and done never asserted -> req_err[g] pulses at cycle 16 after issue; state returns to IDLE. A late vpu_cmd_done is then ignored, and the next request is served normally.
- Corner cases: ready and done asserted in the same cycle -> req_done after 1 cycle with no WAIT_DONE entry. rst pulsed during WAIT_DONE -> all outputs 0, no done or err pulse, rr_ptr=0.
